store_merge_unit: RTL
=====================

# store_merge_unit

Register-to-memory store path for the multicycle datapath, the write-direction counterpart of the write-back selection logic. It takes a register value, byte address and store size (word, halfword, byte) and performs the memory write. Word stores write directly. Sub-word stores do a read-modify-write of the containing word so that untouched byte lanes are preserved. It sits between the control unit (start/done handshake) and the single-port data memory.

## Interface

Parameters:
- READ_LATENCY, 1: cycles from a read address being presented to `mem_rdata` being valid (legal 1..4).

Ports (`name direction width meaning`):
- `clk` input 1: single clock; everything is rising-edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: request pulse; sampled only in IDLE.
- `store_type` input 2: 0 = SW, 1 = SH, 2 = SB, 3 = reserved.
- `addr` input 32: byte address of the store.
- `wdata_reg` input 32: register value; SH uses bits [15:0], SB uses bits [7:0].
- `mem_rdata` input 32: word read from memory.
- `mem_addr` output 32: word-aligned memory address, i.e. {addr[31:2], 2'b00}.
- `mem_wr` output 1: memory write enable, one cycle per store.
- `mem_wdata` output 32: word to write.
- `busy` output 1: high from the cycle after start is accepted until DONE inclusive.
- `done` output 1: one-cycle completion pulse.
- `err` output 1: valid with `done`; misaligned or reserved store, no write performed.

## Operation

- Byte lanes are little-endian:
  - Byte k = addr[1:0] occupies bits [8k+7:8k].
  - Halfword addr[1]=0 occupies [15:0]; addr[1]=1 occupies [31:16].
- Error conditions:
  - SW with addr[1:0]≠0.
  - SH with addr[0]=1.
  - store_type=3.
- In IDLE, on `start`=1, `addr`, `store_type` and `wdata_reg` are latched.
- States:
  - IDLE: outputs idle. On start: error → ERR; SW → WRITE; SH/SB → READ.
  - READ: drive `mem_addr`, `mem_wr`=0 → WAIT.
  - WAIT: hold `mem_addr`. A counter runs READ_LATENCY cycles; on the last cycle `mem_rdata` is captured → MERGE.
  - MERGE: replace the selected lane(s) of the captured word with the latched register data, into a merge register → WRITE.
  - WRITE: `mem_wr`=1, `mem_addr` = aligned address, `mem_wdata` = merged word (SW: latched `wdata_reg`) → DONE.
  - DONE: `done`=1, `err`=0 → IDLE.
  - ERR: `done`=1, `err`=1, `mem_wr` never asserted → IDLE.
- `start` outside IDLE is ignored and is not queued.
- `mem_wr`, `busy`, `done` and `err` are decoded from the state register only. `mem_addr` and `mem_wdata` come from registers.
- Reset values:
  - State IDLE.
  - `mem_wr`=0, `busy`=0, `done`=0, `err`=0.
  - `mem_addr`=0, `mem_wdata`=0, counter 0.
- Reset in any state, including WAIT or WRITE, returns to IDLE at that edge. No pending write is issued afterwards.

## Timing

- `start` is accepted at edge 0.
- SW:
  - WRITE in cycle 1 (`mem_wr`=1).
  - DONE in cycle 2.
  - Total 3 cycles including IDLE.
- SH/SB:
  - READ in cycle 1.
  - WAIT in cycles 2..1+READ_LATENCY.
  - MERGE in cycle 2+RL.
  - WRITE in cycle 3+RL.
  - DONE in cycle 4+RL.
  - With RL=1, `done` arrives in cycle 5.
- Error: ERR in cycle 1 with `done`=`err`=1; memory is untouched.
- Back-to-back: a new `start` may be accepted in the cycle after DONE/ERR, when the state is IDLE again.
- `mem_rdata` is sampled only on the final WAIT cycle; other values are ignored.

## Structure

- Shared package `store_pkg`:
  - Constants ST_SW=2'd0, ST_SH=2'd1, ST_SB=2'd2.
  - State encoding constants (IDLE, READ, WAIT, MERGE, WRITE, DONE, ERR).
  - Constant WORD_ALIGN_MASK.
- One combinational sub-module `byte_lane_merge`:
  - Inputs: old word, register data, addr[1:0], store_type.
  - Output: merged word.
  - Reusable by a future write-buffer.
- FSM, latency counter and registers live in `store_merge_unit`.

## Test plan

- SW, addr=0x100, wdata_reg=0xDEADBEEF:
  - `mem_wr`=1 in cycle 1 with `mem_addr`=0x100, `mem_wdata`=0xDEADBEEF.
  - `done` in cycle 2; no read state entered.
- SB, addr=0x102, wdata_reg=0x000000AB, `mem_rdata`=0x11223344, RL=1:
  - `mem_wdata`=0x11AB3344 with `mem_wr` in cycle 4.
  - `done` in cycle 5.
- SH, addr=0x206, wdata_reg=0xFFFFCAFE, `mem_rdata`=0x11223344, RL=3:
  - `mem_addr`=0x204.
  - `mem_wdata`=0xCAFE3344 with `mem_wr` in cycle 6.
  - `done` in cycle 7.
- Errors:
  - SH at addr=0x101 → `done`=`err`=1 in cycle 1, `mem_wr` never 1.
  - store_type=3 → same response.
  - SW at addr=0x102 → same response.
- `reset` asserted during WAIT of an SB: next cycle IDLE, all outputs 0, no `mem_wr` afterwards. A fresh SW then completes normally.
- `start` held high through an entire SB: only one store performed. A second store is accepted only in the cycle after `done`.

Source files
------------

// File: rtl/store_pkg.sv
// Shared types and constants for the register-to-memory store path.
package store_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 3;

  localparam logic [1:0] ST_SW  = 2'd0;
  localparam logic [1:0] ST_SH  = 2'd1;
  localparam logic [1:0] ST_SB  = 2'd2;
  localparam logic [1:0] ST_RSV = 2'd3;

  localparam logic [DATA_W-1:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_MERGE = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  typedef struct packed {
    logic [1:0]        st;
    logic [1:0]        lane;
    logic [DATA_W-1:0] wdata;
  } store_req_t;

  // Misaligned word/halfword stores and the reserved type are rejected.
  function automatic logic store_is_err(input logic [1:0] st, input logic [1:0] lane);
    logic e;
    e = 1'b0;
    if (st == ST_RSV) e = 1'b1;
    if ((st == ST_SW) && (lane != 2'd0)) e = 1'b1;
    if ((st == ST_SH) && lane[0]) e = 1'b1;
    return e;
  endfunction

endpackage

// File: rtl/store_merge_unit_byte_lane_merge.sv
// Replaces the addressed little-endian byte lane(s) of a word with register data.
module byte_lane_merge
  import store_pkg::*;
(
  input  logic [DATA_W-1:0] old_word,
  input  logic [DATA_W-1:0] reg_data,
  input  logic [1:0]        lane,
  input  logic [1:0]        store_type,
  output logic [DATA_W-1:0] merged_c
);

  always_comb begin
    merged_c = old_word;
    unique case (store_type)
      ST_SW: merged_c = reg_data;
      ST_SH: begin
        if (lane[1]) merged_c[31:16] = reg_data[15:0];
        else         merged_c[15:0]  = reg_data[15:0];
      end
      ST_SB: begin
        unique case (lane)
          2'd0: merged_c[7:0]   = reg_data[7:0];
          2'd1: merged_c[15:8]  = reg_data[7:0];
          2'd2: merged_c[23:16] = reg_data[7:0];
          2'd3: merged_c[31:24] = reg_data[7:0];
          default: merged_c = old_word;
        endcase
      end
      default: merged_c = old_word;
    endcase
  end

endmodule

// File: rtl/store_merge_unit.sv
// Store path: word stores write directly, sub-word stores read-modify-write
// the containing word through a single-port memory.
module store_merge_unit
  import store_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        store_type,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata_reg,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t            state, state_nxt;
  store_req_t        req_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] merged_c;
  logic              start_err_c;
  logic              wait_last_c;

  assign start_err_c = store_is_err(store_type, addr[1:0]);
  assign wait_last_c = (cnt_q == CNT_W'(READ_LATENCY - 1));

  byte_lane_merge u_merge (
    .old_word   (rdata_q),
    .reg_data   (req_q.wdata),
    .lane       (req_q.lane),
    .store_type (req_q.st),
    .merged_c   (merged_c)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state plus control outputs decoded purely from the state register.
  always_comb begin
    state_nxt = state;
    mem_wr    = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    err       = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (start_err_c)              state_nxt = S_ERR;
          else if (store_type == ST_SW) state_nxt = S_WRITE;
          else                          state_nxt = S_READ;
        end
      end
      S_READ:  state_nxt = S_WAIT;
      S_WAIT:  if (wait_last_c) state_nxt = S_MERGE;
      S_MERGE: state_nxt = S_WRITE;
      S_WRITE: begin
        mem_wr    = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      S_ERR: begin
        done      = 1'b1;
        err       = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Request latch, read-latency counter, captured read word and memory-side registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_q     <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            req_q.st    <= store_type;
            req_q.lane  <= addr[1:0];
            req_q.wdata <= wdata_reg;
            cnt_q       <= '0;
            if (!start_err_c) mem_addr <= addr & WORD_ALIGN_MASK;
            if (!start_err_c && (store_type == ST_SW)) mem_wdata <= wdata_reg;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (wait_last_c) rdata_q <= mem_rdata;
        end
        S_MERGE: mem_wdata <= merged_c;
        S_DONE, S_ERR: begin
          cnt_q     <= '0;
          mem_addr  <= '0;
          mem_wdata <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
